// File: rtl/arbitro_banco_reg_if.sv
// Requester A/B handshake, register-bank port and status signals of the
// register-bank arbiter, with master (requesters/bank side) and slave (arbiter) views.
interface arbitro_banco_reg_if;
  logic        req_a;
  logic        we_a;
  logic [4:0]  addr_a;
  logic [31:0] wdata_a;
  logic        ack_a;
  logic [31:0] rdata_a;
  logic        req_b;
  logic        we_b;
  logic [4:0]  addr_b;
  logic [31:0] wdata_b;
  logic        ack_b;
  logic [31:0] rdata_b;
  logic [4:0]  RR1;
  logic [4:0]  WriteReg;
  logic [31:0] Writedata;
  logic        Regwrite;
  logic [31:0] RD1;
  logic        busy;
  logic [1:0]  grant;

  modport master (
    output req_a, we_a, addr_a, wdata_a, req_b, we_b, addr_b, wdata_b, RD1,
    input  ack_a, rdata_a, ack_b, rdata_b, RR1, WriteReg, Writedata, Regwrite, busy, grant
  );

  modport slave (
    input  req_a, we_a, addr_a, wdata_a, req_b, we_b, addr_b, wdata_b, RD1,
    output ack_a, rdata_a, ack_b, rdata_b, RR1, WriteReg, Writedata, Regwrite, busy, grant
  );
endinterface

// File: rtl/arbitro_banco_reg.sv
// Round-robin arbiter giving two requesters access to a single register-bank port.
// Each transaction takes IDLE -> SERVE -> RESP; all outputs are registered.
module arbitro_banco_reg #(
  parameter bit PROTECT_R0 = 1'b1
) (
  input logic                clk,
  input logic                reset,
  arbitro_banco_reg_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      state_r;
  logic        last_b_r;
  logic [1:0]  grant_r;
  logic        we_r;
  logic        busy_r;
  logic        ack_a_r;
  logic        ack_b_r;
  logic        regwrite_r;
  logic [4:0]  addr_r;
  logic [31:0] writedata_r;
  logic [31:0] rdata_a_r;
  logic [31:0] rdata_b_r;

  logic        pick_b_s;
  logic        sel_we_s;
  logic [4:0]  sel_addr_s;
  logic [31:0] sel_wdata_s;

  // On a tie the requester that was not served last wins.
  function automatic logic choose_b(input logic ra, input logic rb, input logic lb);
    if (ra && rb) begin
      return !lb;
    end else begin
      return rb;
    end
  endfunction

  // Select the winning requester and its transaction fields.
  always_comb begin
    pick_b_s = choose_b(bus.req_a, bus.req_b, last_b_r);
    if (pick_b_s) begin
      sel_we_s    = bus.we_b;
      sel_addr_s  = bus.addr_b;
      sel_wdata_s = bus.wdata_b;
    end else begin
      sel_we_s    = bus.we_a;
      sel_addr_s  = bus.addr_a;
      sel_wdata_s = bus.wdata_a;
    end
  end

  // Transaction FSM with all bank and handshake outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      last_b_r    <= 1'b1;
      grant_r     <= 2'b00;
      we_r        <= 1'b0;
      busy_r      <= 1'b0;
      ack_a_r     <= 1'b0;
      ack_b_r     <= 1'b0;
      regwrite_r  <= 1'b0;
      addr_r      <= 5'd0;
      writedata_r <= 32'd0;
      rdata_a_r   <= 32'd0;
      rdata_b_r   <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_a || bus.req_b) begin
            state_r     <= SERVE;
            busy_r      <= 1'b1;
            last_b_r    <= pick_b_s;
            grant_r     <= pick_b_s ? 2'b10 : 2'b01;
            we_r        <= sel_we_s;
            addr_r      <= sel_addr_s;
            writedata_r <= sel_wdata_s;
            // Register 0 may be read-only: the handshake still runs, the write is dropped.
            regwrite_r  <= sel_we_s && !(PROTECT_R0 && (sel_addr_s == 5'd0));
          end else begin
            state_r <= IDLE;
          end
        end
        SERVE: begin
          state_r     <= RESP;
          regwrite_r  <= 1'b0;
          writedata_r <= 32'd0;
          ack_a_r     <= grant_r[0];
          ack_b_r     <= grant_r[1];
          if (!we_r && grant_r[0]) begin
            rdata_a_r <= bus.RD1;
          end else if (!we_r && grant_r[1]) begin
            rdata_b_r <= bus.RD1;
          end else begin
            rdata_a_r <= rdata_a_r;
          end
        end
        RESP: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          grant_r <= 2'b00;
          ack_a_r <= 1'b0;
          ack_b_r <= 1'b0;
          addr_r  <= 5'd0;
        end
        default: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          grant_r     <= 2'b00;
          ack_a_r     <= 1'b0;
          ack_b_r     <= 1'b0;
          regwrite_r  <= 1'b0;
          addr_r      <= 5'd0;
          writedata_r <= 32'd0;
        end
      endcase
    end
  end

  assign bus.ack_a     = ack_a_r;
  assign bus.ack_b     = ack_b_r;
  assign bus.rdata_a   = rdata_a_r;
  assign bus.rdata_b   = rdata_b_r;
  assign bus.RR1       = addr_r;
  assign bus.WriteReg  = addr_r;
  assign bus.Writedata = writedata_r;
  assign bus.Regwrite  = regwrite_r;
  assign bus.busy      = busy_r;
  assign bus.grant     = grant_r;

endmodule

// File: tb/tb_arbitro_banco_reg.sv
// Self-checking bench for arbitro_banco_reg: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_arbitro_banco_reg;
  localparam bit PROT = 1'b1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  arbitro_banco_reg_if bus();
  arbitro_banco_reg #(.PROTECT_R0(PROT)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rw_count = 0;
  int acka_count = 0;
  int ackb_count = 0;

  // Register bank environment: known pattern on reset, written by the arbiter.
  logic [31:0] bank [0:31];
  assign bus.RD1 = bank[bus.RR1];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) bank[i] <= 32'hA000_0000 + 32'(i);
    end else if (bus.Regwrite === 1'b1) begin
      bank[bus.WriteReg] <= bus.Writedata;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model: age -1 = no transaction, 0 = serving cycle, 1 = acknowledge cycle.
  int          m_age = -1;
  int          m_owner = 0;
  int          m_last = 1;
  logic        m_we = 1'b0;
  logic [4:0]  m_addr = 5'd0;
  logic [31:0] m_wdata = 32'd0;
  logic [31:0] m_rda = 32'd0;
  logic [31:0] m_rdb = 32'd0;
  bit          m_started = 1'b0;

  function automatic int pick(input logic ra, input logic rb, input int last);
    if (ra && rb) return (last == 1) ? 0 : 1;
    return rb ? 1 : 0;
  endfunction

  // Transaction-level reference model of the arbiter.
  always @(posedge clk) begin
    if (reset) begin
      m_age <= -1; m_last <= 1; m_rda <= 32'd0; m_rdb <= 32'd0; m_started <= 1'b1;
    end else if (m_age < 0) begin
      if (bus.req_a || bus.req_b) begin
        m_age   <= 0;
        m_owner <= pick(bus.req_a, bus.req_b, m_last);
        m_last  <= pick(bus.req_a, bus.req_b, m_last);
        m_we    <= (pick(bus.req_a, bus.req_b, m_last) == 1) ? bus.we_b : bus.we_a;
        m_addr  <= (pick(bus.req_a, bus.req_b, m_last) == 1) ? bus.addr_b : bus.addr_a;
        m_wdata <= (pick(bus.req_a, bus.req_b, m_last) == 1) ? bus.wdata_b : bus.wdata_a;
      end
    end else if (m_age == 0) begin
      m_age <= 1;
      if (!m_we && m_owner == 0) m_rda <= bank[m_addr];
      if (!m_we && m_owner == 1) m_rdb <= bank[m_addr];
    end else begin
      m_age <= -1;
    end
  end

  // Compare process: every cycle, on the falling edge.
  initial forever begin
    @(negedge clk);
    if (m_started) begin
      check("busy", 32'(bus.busy), 32'(m_age >= 0));
      check("grant", 32'(bus.grant), (m_age < 0) ? 32'd0 : ((m_owner == 1) ? 32'd2 : 32'd1));
      check("ack_a", 32'(bus.ack_a), 32'(m_age == 1 && m_owner == 0));
      check("ack_b", 32'(bus.ack_b), 32'(m_age == 1 && m_owner == 1));
      check("RR1", 32'(bus.RR1), (m_age >= 0) ? 32'(m_addr) : 32'd0);
      check("WriteReg", 32'(bus.WriteReg), (m_age >= 0) ? 32'(m_addr) : 32'd0);
      check("Regwrite", 32'(bus.Regwrite),
            32'(m_age == 0 && m_we && !(PROT && m_addr == 5'd0)));
      check("Writedata", bus.Writedata, (m_age == 0) ? m_wdata : 32'd0);
      check("rdata_a", bus.rdata_a, m_rda);
      check("rdata_b", bus.rdata_b, m_rdb);
      if (bus.Regwrite === 1'b1) rw_count++;
      if (bus.ack_a === 1'b1) acka_count++;
      if (bus.ack_b === 1'b1) ackb_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_a = 1'b0; bus.we_a = 1'b0; bus.addr_a = 5'd0; bus.wdata_a = 32'd0;
    bus.req_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = 5'd0; bus.wdata_b = 32'd0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_ack(input int side, output int edges);
    bit found;
    found = 1'b0;
    edges = 0;
    while (!found && edges < 10) begin
      tick();
      edges++;
      if (((side == 0) ? bus.ack_a : bus.ack_b) === 1'b1) found = 1'b1;
    end
    check("ack_timeout", 32'(found), 32'd1);
  endtask

  int e, ca, cb, n, base, base2;
  logic [1:0] got [0:2];

  initial begin
    do_reset();
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_grant", 32'(bus.grant), 32'd0);

    // A writes 0x12345678 to register 5, then reads it back.
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 5'd5; bus.wdata_a = 32'h1234_5678;
    tick();
    check("wr_regwrite", 32'(bus.Regwrite), 32'd1);
    check("wr_writereg", 32'(bus.WriteReg), 32'd5);
    tick();
    check("wr_ack_n2", 32'(bus.ack_a), 32'd1);
    bus.req_a = 1'b0; bus.we_a = 1'b0;
    tick();
    bus.req_a = 1'b1;
    wait_ack(0, e);
    check("rd_latency", 32'(e), 32'd2);
    check("rd_data", bus.rdata_a, 32'h1234_5678);
    bus.req_a = 1'b0;
    tick();

    // Both request from reset: A first, B three cycles later.
    do_reset();
    bus.req_a = 1'b1; bus.addr_a = 5'd3;
    bus.req_b = 1'b1; bus.addr_b = 5'd7;
    wait_ack(0, e);
    ca = cyc;
    check("tie_grant_a", 32'(bus.grant), 32'd1);
    check("tie_rdata_a", bus.rdata_a, 32'hA000_0003);
    bus.req_a = 1'b0;
    wait_ack(1, e);
    cb = cyc;
    check("tie_grant_b", 32'(bus.grant), 32'd2);
    check("tie_spacing", 32'(cb - ca), 32'd3);
    check("tie_rdata_b", bus.rdata_b, 32'hA000_0007);
    bus.req_b = 1'b0;
    tick();

    // B holds its request, A asks once: B, A, B.
    do_reset();
    bus.req_b = 1'b1; bus.addr_b = 5'd2;
    tick();
    bus.req_a = 1'b1; bus.addr_a = 5'd4;
    n = 0;
    for (int k = 0; k < 15 && n < 3; k++) begin
      tick();
      if (bus.ack_a === 1'b1 || bus.ack_b === 1'b1) begin
        got[n] = bus.grant;
        n++;
        if (bus.ack_a === 1'b1) bus.req_a = 1'b0;
      end
    end
    check("rr_count", 32'(n), 32'd3);
    check("rr_first", 32'(got[0]), 32'd2);
    check("rr_second", 32'(got[1]), 32'd1);
    check("rr_third", 32'(got[2]), 32'd2);
    bus.req_b = 1'b0;
    tick(); tick(); tick();

    // Write to protected register 0.
    do_reset();
    base = rw_count;
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 5'd0; bus.wdata_a = 32'hFFFF_FFFF;
    wait_ack(0, e);
    check("r0_latency", 32'(e), 32'd2);
    bus.req_a = 1'b0; bus.we_a = 1'b0;
    tick();
    check("r0_no_regwrite", 32'(rw_count - base), 32'd0);
    check("r0_bank", bank[0], 32'hA000_0000);

    // Reset in the middle of a B write.
    do_reset();
    base = ackb_count;
    bus.req_b = 1'b1; bus.we_b = 1'b1; bus.addr_b = 5'd9; bus.wdata_b = 32'hDEAD_BEEF;
    tick();
    check("abort_serve_rw", 32'(bus.Regwrite), 32'd1);
    reset = 1'b1;
    bus.req_b = 1'b0; bus.we_b = 1'b0;
    tick();
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_regwrite", 32'(bus.Regwrite), 32'd0);
    check("abort_grant", 32'(bus.grant), 32'd0);
    reset = 1'b0;
    base2 = rw_count;
    tick(); tick(); tick();
    check("abort_no_ack_b", 32'(ackb_count - base), 32'd0);
    check("abort_no_rw", 32'(rw_count - base2), 32'd0);

    // A read where req_a drops during SERVE.
    base = acka_count;
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 5'd11;
    tick();
    bus.req_a = 1'b0;
    tick();
    check("drop_ack", 32'(bus.ack_a), 32'd1);
    check("drop_rdata", bus.rdata_a, 32'hA000_000B);
    tick(); tick(); tick();
    check("drop_ack_once", 32'(acka_count - base), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/arbitro_banco_reg.md
ARBITRO_BANCO_REG -- requirements
Module: arbitro_banco_reg

Interface
REQ-001 Parameter: PROTECT_R0, 1, when 1 writes to register 0 are suppressed (handshake still completes).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_a  input  1  requester A transaction request; held high until ack_a.
REQ-005 we_a  input  1  requester A: 1 = write, 0 = read; stable while req_a high.
REQ-006 addr_a  input  5  requester A register address; stable while req_a high.
REQ-007 wdata_a  input  32  requester A write data; stable while req_a high.
REQ-008 ack_a  output  1  one-cycle completion pulse to A.
REQ-009 rdata_a  output  32  read data to A; valid in the ack_a cycle, held until next A read completes.
REQ-010 req_b, we_b, addr_b, wdata_b, ack_b, rdata_b  same widths and meaning as the A ports, for requester B.
REQ-011 RR1  output  5  bank read address.
REQ-012 WriteReg  output  5  bank write address.
REQ-013 Writedata  output  32  bank write data.
REQ-014 Regwrite  output  1  bank write enable.
REQ-015 RD1  input  32  bank read data (combinational from RR1).
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 grant  output  2  one-hot owner: 01 = A, 10 = B, 00 = none.

Function
REQ-018 FSM states SHALL be IDLE, SERVE, RESP; IDLE->SERVE when req_a or req_b high; SERVE->RESP unconditionally; RESP->IDLE unconditionally.
REQ-019 On IDLE->SERVE the block SHALL register grant, we, addr and wdata of the chosen requester; these stay constant through SERVE and RESP.
REQ-020 Arbitration: only one request high -> grant it; both high -> grant the requester not served last (round-robin pointer updated on each IDLE->SERVE).
REQ-021 RR1 and WriteReg SHALL equal the latched address in SERVE and RESP, 0 in IDLE.
REQ-022 Regwrite SHALL be 1 only in SERVE, only for a latched write, and 0 if PROTECT_R0=1 and address = 0.
REQ-023 Writedata SHALL equal latched wdata in SERVE, 0 otherwise.
REQ-024 For a read, RD1 SHALL be captured at the SERVE->RESP edge into rdata of the granted requester; rdata of the other requester unchanged.
REQ-025 A write SHALL NOT modify either rdata output.
REQ-026 ack of the granted requester SHALL be 1 exactly in RESP; both acks 0 in every other state.
REQ-027 Latency: request seen in IDLE at edge N -> SERVE cycle N+1 -> ack cycle N+2; back-to-back transactions every 3 cycles.
REQ-028 Requests arriving while busy SHALL be ignored until IDLE, then arbitrated normally; a requester still holding req in the cycle after its ack is treated as a new request.
REQ-029 If req of the granted requester drops during SERVE/RESP, the transaction SHALL still complete with ack.
REQ-030 Simultaneous requests with equal priority after reset SHALL favour A (pointer resets to "B served last").

Reset
REQ-031 reset high at a rising edge SHALL force state IDLE, grant 00, busy 0, ack_a/ack_b 0, Regwrite 0, RR1/WriteReg/Writedata 0, rdata_a/rdata_b 0, pointer = B-last, regardless of state.
REQ-032 Reset during SERVE SHALL abort the transaction: no ack issued, no further Regwrite after the reset edge.

Verification
REQ-033 A write addr 5 data 0x12345678, then A read addr 5 -> Regwrite 1 in SERVE with WriteReg 5; second ack_a cycle rdata_a = 0x12345678.
REQ-034 req_a and req_b both high from reset, each reading a distinct register -> A served first (grant 01), B next (grant 10), acks 3 cycles apart.
REQ-035 B holds req continuously, A requests once -> grants alternate B, A, B; no requester served twice while the other waits.
REQ-036 A write addr 0 data 0xFFFFFFFF with PROTECT_R0=1 -> Regwrite never 1, ack_a still pulses at N+2.
REQ-037 Reset asserted in SERVE of a B write -> next cycle busy 0, ack_b never pulses, Regwrite 0.
REQ-038 A read, A drops req_a during SERVE -> ack_a still pulses once, rdata_a = RD1 value of latched address.
